// File: rtl/jk_down_counter_4bit.sv
// Synchronous down counter built from WIDTH JK flip-flop cells, with parallel load,
// count enable, a borrow output for cascading and a sticky underflow flag.
module jk_down_counter_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             count_enable,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             borrow_out,
    output logic             underflow
);

    typedef enum logic [1:0] {
        ModeIdle,
        ModeCount,
        ModeLoad,
        ModeClear
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             underflow_q;
    logic             underflow_d;
    logic             q_is_zero;

    assign q_is_zero = (q_q == '0);

    always_comb begin
        mode = ModeIdle;
        if (clear) begin
            mode = ModeClear;
        end else if (load) begin
            mode = ModeLoad;
        end else if (count_enable) begin
            mode = ModeCount;
        end
    end

    // Bit i toggles when counting and every lower bit is zero (borrow ripples up).
    always_comb begin
        toggle    = '0;
        toggle[0] = count_enable;
        for (int i = 1; i < int'(WIDTH); i++) begin
            toggle[i] = toggle[i-1] & ~q_q[i-1];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        unique case (mode)
            ModeClear: begin
                j = '0;
                k = '1;
            end
            ModeLoad: begin
                j = d;
                k = ~d;
            end
            ModeCount: begin
                j = toggle;
                k = toggle;
            end
            default: begin
                j = '0;
                k = '0;
            end
        endcase
    end

    // JK characteristic equation, applied per cell.
    assign q_d = (j & ~q_q) | (~k & q_q);

    always_comb begin
        underflow_d = underflow_q;
        unique case (mode)
            ModeClear, ModeLoad: underflow_d = 1'b0;
            ModeCount:           underflow_d = underflow_q | q_is_zero;
            default:             underflow_d = underflow_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            q_q         <= '0;
            underflow_q <= 1'b0;
        end else begin
            q_q         <= q_d;
            underflow_q <= underflow_d;
        end
    end

    assign q          = q_q;
    assign zero       = q_is_zero;
    assign borrow_out = count_enable & q_is_zero;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_jk_down_counter_4bit.sv
// Scoreboard bench: a single 4-bit counter plus a two-stage cascade, both checked
// against arithmetic reference models on the falling edge.
module tb_jk_down_counter_4bit;

    logic       clock;
    logic       clear, load, count_enable;
    logic [3:0] d;
    logic [3:0] q;
    logic       zero, borrow_out, underflow;

    logic       c_clear, c_load, c_ce;
    logic [7:0] c_d;
    logic [3:0] lo_q, hi_q;
    logic       lo_zero, hi_zero, lo_borrow, hi_borrow, lo_uf, hi_uf;

    int n_pass;
    int n_total;

    typedef struct packed {
        logic [3:0] q;
        logic       uf;
    } exp_t;

    typedef struct packed {
        logic [7:0] v;
        logic       uf_lo;
        logic       uf_hi;
    } cexp_t;

    exp_t  exp_q[$];
    cexp_t cexp_q[$];

    // Reference model state
    int unsigned m_q, m_uf;
    int unsigned m_v, m_uf_lo, m_uf_hi;

    jk_down_counter_4bit #(.WIDTH(4)) dut (
        .clock       (clock),
        .clear       (clear),
        .load        (load),
        .d           (d),
        .count_enable(count_enable),
        .q           (q),
        .zero        (zero),
        .borrow_out  (borrow_out),
        .underflow   (underflow)
    );

    jk_down_counter_4bit #(.WIDTH(4)) u_lo (
        .clock       (clock),
        .clear       (c_clear),
        .load        (c_load),
        .d           (c_d[3:0]),
        .count_enable(c_ce),
        .q           (lo_q),
        .zero        (lo_zero),
        .borrow_out  (lo_borrow),
        .underflow   (lo_uf)
    );

    jk_down_counter_4bit #(.WIDTH(4)) u_hi (
        .clock       (clock),
        .clear       (c_clear),
        .load        (c_load),
        .d           (c_d[7:4]),
        .count_enable(lo_borrow),
        .q           (hi_q),
        .zero        (hi_zero),
        .borrow_out  (hi_borrow),
        .underflow   (hi_uf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    endtask

    // One clock edge: advance both models and queue the expected post-edge state.
    task automatic tick();
        exp_t  e;
        cexp_t ce;
        @(posedge clock);
        if (clear) begin
            m_q = 0; m_uf = 0;
        end else if (load) begin
            m_q = d; m_uf = 0;
        end else if (count_enable) begin
            if (m_q == 0) begin
                m_q = 15; m_uf = 1;
            end else begin
                m_q = m_q - 1;
            end
        end
        if (c_clear) begin
            m_v = 0; m_uf_lo = 0; m_uf_hi = 0;
        end else if (c_load) begin
            m_v = c_d; m_uf_lo = 0; m_uf_hi = 0;
        end else if (c_ce) begin
            if (m_v % 16 == 0) m_uf_lo = 1;
            if (m_v == 0) m_uf_hi = 1;
            m_v = (m_v + 255) % 256;
        end
        e.q = m_q[3:0]; e.uf = m_uf[0];
        exp_q.push_back(e);
        ce.v = m_v[7:0]; ce.uf_lo = m_uf_lo[0]; ce.uf_hi = m_uf_hi[0];
        cexp_q.push_back(ce);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: compares whatever the DUTs present against the queued expectations.
    always @(negedge clock) begin
        exp_t  e;
        cexp_t ce;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("q", 32'(q), 32'(e.q));
            chk("underflow", 32'(underflow), 32'(e.uf));
            chk("zero", 32'(zero), 32'(e.q == 4'd0));
            chk("borrow_out", 32'(borrow_out), 32'(count_enable && e.q == 4'd0));
        end
        if (cexp_q.size() > 0) begin
            ce = cexp_q.pop_front();
            chk("cascade_value", 32'({hi_q, lo_q}), 32'(ce.v));
            chk("cascade_lo_underflow", 32'(lo_uf), 32'(ce.uf_lo));
            chk("cascade_hi_underflow", 32'(hi_uf), 32'(ce.uf_hi));
            chk("cascade_hi_borrow", 32'(hi_borrow), 32'(c_ce && ce.v == 8'd0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        n_pass = 0; n_total = 0;
        m_q = 0; m_uf = 0; m_v = 0; m_uf_lo = 0; m_uf_hi = 0;
        c_clear = 1'b1; c_load = 1'b1; c_d = 8'hA5; c_ce = 1'b1;

        // Reset with load and count_enable also asserted
        clear = 1'b1; load = 1'b1; d = 4'b1010; count_enable = 1'b1;
        tick();

        // Full-cycle decrement through the wrap
        clear = 1'b0; load = 1'b0;
        c_clear = 1'b0; c_load = 1'b0; c_ce = 1'b0;
        ticks(17);

        // Load with count_enable high, hold, then count to zero
        load = 1'b1; d = 4'b0101;
        tick();
        load = 1'b0; count_enable = 1'b0;
        ticks(3);
        count_enable = 1'b1;
        ticks(5);

        // Priority: clear over load, load over count
        clear = 1'b1; load = 1'b1; d = 4'b1111;
        tick();
        clear = 1'b0; d = 4'b0011;
        tick();
        load = 1'b1; d = 4'b1001;
        tick();
        load = 1'b0;
        ticks(2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();

        // Cascade: 0x10 -> 0x0F -> ... -> 0x00 -> 0xFF
        c_load = 1'b1; c_d = 8'h10;
        tick();
        c_load = 1'b0; c_ce = 1'b1;
        ticks(17);
        c_ce = 1'b0;
        tick();

        // Randomised traffic on both counters
        for (int i = 0; i < 300; i++) begin
            clear        = ($urandom_range(0, 19) == 0);
            load         = ($urandom_range(0, 9) == 0);
            d            = 4'($urandom);
            count_enable = ($urandom_range(0, 3) != 0);
            c_clear      = ($urandom_range(0, 29) == 0);
            c_load       = ($urandom_range(0, 14) == 0);
            c_d          = 8'($urandom);
            c_ce         = ($urandom_range(0, 4) != 0);
            tick();
        end

        @(negedge clock);
        @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size() + cexp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
